// File: rtl/snn_pkg.sv
// Shared SNN definitions: image geometry and the loader state encoding.
package snn_pkg;

  localparam int IMG_BYTES = 98;
  localparam int IMG_BITS  = IMG_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_START,
    ST_WAIT_CORE
  } loader_state_e;

endpackage

// File: rtl/img_loader_if.sv
// Bus between the UART/SNN environment and the image loader.
interface img_loader_if #(
  parameter int ADDR_W = 10
);

  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              core_done;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_data;
  logic              ram_own;
  logic              start;
  logic              busy;
  logic              overrun;

  // master is the environment side; slave is the loader itself
  modport master (
    output rx_rdy, rx_data, core_done,
    input  ram_we, ram_addr, ram_data, ram_own, start, busy, overrun
  );

  modport slave (
    input  rx_rdy, rx_data, core_done,
    output ram_we, ram_addr, ram_data, ram_own, start, busy, overrun
  );

endinterface

// File: rtl/img_loader.sv
// Unpacks UART bytes LSB-first into the 1-bit input RAM and starts the SNN core
// once a full frame is loaded; a one-byte pending buffer absorbs bytes that arrive while busy.
module img_loader #(
  parameter int IMG_BYTES = snn_pkg::IMG_BYTES,
  parameter int ADDR_W    = 10
) (
  input logic         clk,
  input logic         rst,
  img_loader_if.slave bus
);
  import snn_pkg::*;

  localparam int BYTE_W = $clog2(IMG_BYTES + 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(IMG_BYTES - 1);

  loader_state_e     state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              pend_valid_q, pend_valid_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic              overrun_q, overrun_d;
  logic              consume;
  logic              last_bit;

  assign last_bit = (pix_q[2:0] == 3'd7);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    pix_d        = pix_q;
    byte_d       = byte_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    overrun_d    = overrun_q;
    consume      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          shift_d = pend_data_q;
          consume = 1'b1;
          state_d = ST_UNPACK;
        end else if (bus.rx_rdy) begin
          shift_d = bus.rx_data;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        shift_d = {1'b0, shift_q[7:1]};
        if (!last_bit) begin
          pix_d = pix_q + ADDR_W'(1);
        end else begin
          byte_d = byte_q + BYTE_W'(1);
          // the final pixel address is held so the counter never leaves the image
          if (byte_q == LAST_BYTE) begin
            state_d = ST_START;
          end else begin
            pix_d = pix_q + ADDR_W'(1);
            if (pend_valid_q) begin
              shift_d = pend_data_q;
              consume = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_START: begin
        pix_d   = '0;
        byte_d  = '0;
        state_d = ST_WAIT_CORE;
      end
      ST_WAIT_CORE: begin
        if (bus.core_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (consume) pend_valid_d = 1'b0;

    // a byte that arrives as the pending slot drains is kept, not dropped
    if (bus.rx_rdy && !(state_q == ST_IDLE && !pend_valid_q)) begin
      if (pend_valid_q && !consume) begin
        overrun_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_data_d  = bus.rx_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      pix_q        <= '0;
      byte_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      pix_q        <= pix_d;
      byte_q       <= byte_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.ram_we   = (state_q == ST_UNPACK);
  assign bus.ram_own  = (state_q == ST_UNPACK);
  assign bus.ram_addr = pix_q;
  assign bus.ram_data = shift_q[0];
  assign bus.start    = (state_q == ST_START);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.overrun  = overrun_q;

endmodule
